// File: rtl/mips32_pipe_ctrl.sv
// Hazard, flush and halt controller for a 5-stage MIPS32 pipeline.
// Define MIPS32_FWD_EN to enable EX/MEM and MEM/WB operand forwarding (load-use stall only).
module mips32_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] id_ir,
    input  logic        mem_br_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        pipe_we,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        halted
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       is_load;
    } sb_entry_t;

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    state_t     state_reg;
    logic [1:0] drain_cnt_reg;
    logic       halted_reg;
    sb_entry_t  sb_reg [3];

    logic [5:0] opcode;
    logic [4:0] src [2];
    logic [1:0] src_use;
    sb_entry_t  dec_entry;
    logic       dec_hlt;
    logic [1:0] src_stall;
    logic [1:0] fwd_sel [2];
    logic       stall;
    logic       br;
    sb_entry_t  sb_ex_next;
    sb_entry_t  sb_mem_next;

    assign opcode = id_ir[31:26];
    assign src[0] = id_ir[25:21];
    assign src[1] = id_ir[20:16];
    assign br     = mem_br_taken;

    always_comb begin
        src_use   = 2'b00;
        dec_entry = '0;
        dec_hlt   = 1'b0;
        case (opcode)
            6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100: begin
                src_use         = 2'b11;
                dec_entry.valid = 1'b1;
                dec_entry.dst   = id_ir[15:11];
            end
            6'b001000: begin
                src_use           = 2'b01;
                dec_entry.valid   = 1'b1;
                dec_entry.dst     = id_ir[20:16];
                dec_entry.is_load = 1'b1;
            end
            6'b001010, 6'b001011, 6'b001100: begin
                src_use         = 2'b01;
                dec_entry.valid = 1'b1;
                dec_entry.dst   = id_ir[20:16];
            end
            6'b001001:            src_use = 2'b11;
            6'b001101, 6'b001110: src_use = 2'b01;
            6'b111111:            dec_hlt = 1'b1;
            default: ;
        endcase
        // r0 is hardwired to zero, so writing it never creates a hazard
        if (dec_entry.dst == 5'd0) begin
            dec_entry.valid = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic hit_ex;
        logic hit_mem;
        assign hit_ex  = src_use[gi] && sb_reg[SB_EX].valid  && (sb_reg[SB_EX].dst  == src[gi]);
        assign hit_mem = src_use[gi] && sb_reg[SB_MEM].valid && (sb_reg[SB_MEM].dst == src[gi]);
`ifdef MIPS32_FWD_EN
        assign src_stall[gi] = hit_ex && sb_reg[SB_EX].is_load;
        assign fwd_sel[gi]   = !rst_n                                 ? 2'd0 :
                               (hit_ex && !sb_reg[SB_EX].is_load)     ? 2'd1 :
                               hit_mem                                ? 2'd2 : 2'd0;
`else
        assign src_stall[gi] = hit_ex || hit_mem;
        assign fwd_sel[gi]   = 2'd0;
`endif
    end

    assign stall     = |src_stall;
    assign fwd_a_sel = fwd_sel[0];
    assign fwd_b_sel = fwd_sel[1];
    assign halted    = halted_reg;

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        pipe_we     = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (!rst_n) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            pipe_we = 1'b1;
        end else if (en) begin
            case (state_reg)
                RUN, DRAIN: begin
                    if (br) begin
                        // a taken branch squashes everything younger, overriding stalls and HLT
                        pc_we       = 1'b1;
                        ifid_we     = 1'b1;
                        pipe_we     = 1'b1;
                        flush_ifid  = 1'b1;
                        flush_idex  = 1'b1;
                        flush_exmem = 1'b1;
                    end else if (state_reg == DRAIN || stall || dec_hlt) begin
                        pipe_we    = 1'b1;
                        flush_idex = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        pipe_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sb_ex_next  = (br || stall || state_reg != RUN) ? '0 : dec_entry;
        sb_mem_next = br ? '0 : sb_reg[SB_EX];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            drain_cnt_reg <= 2'd0;
            halted_reg    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                sb_reg[i] <= '0;
            end
        end else if (en && state_reg != HALTED) begin
            sb_reg[SB_EX]  <= sb_ex_next;
            sb_reg[SB_MEM] <= sb_mem_next;
            sb_reg[SB_WB]  <= sb_reg[SB_MEM];
            case (state_reg)
                RUN: begin
                    if (!br && !stall && dec_hlt) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= 2'd3;
                    end
                end
                DRAIN: begin
                    if (br) begin
                        state_reg     <= RUN;
                        drain_cnt_reg <= 2'd0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 2'd1;
                        if (drain_cnt_reg == 2'd1) begin
                            state_reg  <= HALTED;
                            halted_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // WB entry is kept for completeness of the scoreboard; the register file resolves it.
    logic sink_unused;
    assign sink_unused = ^{id_ir[10:0], sb_reg[SB_WB], sb_reg[SB_MEM].is_load, sb_reg[SB_EX].is_load};

endmodule

// File: tb/tb_mips32_pipe_ctrl.sv
// Randomised and directed bench for mips32_pipe_ctrl against a behavioural pipeline model.
module tb_mips32_pipe_ctrl;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] id_ir;
    logic        mem_br_taken;
    logic        pc_we, ifid_we, pipe_we;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        halted;

    mips32_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .id_ir(id_ir), .mem_br_taken(mem_br_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .pipe_we(pipe_we),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, ifid, pipe, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b, halted}
    logic [10:0] obs;
    assign obs = {pc_we, ifid_we, pipe_we, flush_ifid, flush_idex, flush_exmem,
                  fwd_a_sel, fwd_b_sel, halted};
    localparam logic [10:0] RST_VEC = 11'b111_000_00_00_0;

`ifdef MIPS32_FWD_EN
    localparam int RAW_STALLS = 0;
    localparam int RAW_FWD    = 1;
    localparam int LU_STALLS  = 1;
    localparam int LU_FWD     = 2;
`else
    localparam int RAW_STALLS = 2;
    localparam int RAW_FWD    = 0;
    localparam int LU_STALLS  = 2;
    localparam int LU_FWD     = 0;
`endif

    localparam logic [31:0] I_ADDI_R1 = {6'b001010, 5'd0, 5'd1, 16'd5};
    localparam logic [31:0] I_ADD_R2  = {6'b000000, 5'd1, 5'd1, 5'd2, 11'd0};
    localparam logic [31:0] I_LW_R3   = {6'b001000, 5'd0, 5'd3, 16'd0};
    localparam logic [31:0] I_SUB_R4  = {6'b000001, 5'd3, 5'd0, 5'd4, 11'd0};
    localparam logic [31:0] I_HLT     = {6'b111111, 26'd0};

    int checks = 0;
    int errors = 0;

    // Model: state 0=RUN 1=DRAIN 2=HALTED; in-flight destinations (0 means none)
    int          m_state, m_cnt, m_ex_dst, m_mem_dst;
    bit          m_ex_ld;
    logic [31:0] cur_ir;
    bit          cur_br, cur_en;
    logic [10:0] exp_vec;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_ex_dst = 0; m_mem_dst = 0; m_ex_ld = 0;
    endtask

    task automatic decode(input logic [31:0] ir, output int sa, output int sb,
                          output int dst, output bit ld, output bit hlt);
        int op;
        op = int'(ir[31:26]);
        sa = 0; sb = 0; dst = 0; ld = 0; hlt = 0;
        if (op <= 4) begin
            sa = int'(ir[25:21]); sb = int'(ir[20:16]); dst = int'(ir[15:11]);
        end else if (op == 8 || op == 10 || op == 11 || op == 12) begin
            sa = int'(ir[25:21]); dst = int'(ir[20:16]); ld = (op == 8);
        end else if (op == 9) begin
            sa = int'(ir[25:21]); sb = int'(ir[20:16]);
        end else if (op == 13 || op == 14) begin
            sa = int'(ir[25:21]);
        end else if (op == 63) begin
            hlt = 1;
        end
    endtask

    function automatic bit src_stalls(int s);
`ifdef MIPS32_FWD_EN
        return s != 0 && s == m_ex_dst && m_ex_ld;
`else
        return s != 0 && (s == m_ex_dst || s == m_mem_dst);
`endif
    endfunction

    function automatic logic [1:0] src_fwd(int s);
`ifdef MIPS32_FWD_EN
        if (s != 0 && s == m_ex_dst && !m_ex_ld) return 2'd1;
        if (s != 0 && s == m_mem_dst) return 2'd2;
`endif
        return 2'd0;
    endfunction

    task automatic model_eval();
        int sa, sb, dst;
        bit ld, hlt, st;
        logic [2:0] we, fl;
        decode(cur_ir, sa, sb, dst, ld, hlt);
        st = src_stalls(sa) || src_stalls(sb);
        we = 3'b000; fl = 3'b000;
        if (cur_en && m_state != 2) begin
            if (cur_br) begin
                we = 3'b111; fl = 3'b111;
            end else if (m_state == 1 || st || hlt) begin
                we = 3'b001; fl = 3'b010;
            end else begin
                we = 3'b111;
            end
        end
        exp_vec = {we, fl, src_fwd(sa), src_fwd(sb), m_state == 2};
    endtask

    task automatic model_commit();
        int sa, sb, dst;
        bit ld, hlt, st;
        if (!cur_en || m_state == 2) return;
        decode(cur_ir, sa, sb, dst, ld, hlt);
        st = src_stalls(sa) || src_stalls(sb);
        m_mem_dst = cur_br ? 0 : m_ex_dst;
        if (m_state == 0 && !cur_br && !st) begin
            m_ex_dst = dst; m_ex_ld = ld;
        end else begin
            m_ex_dst = 0; m_ex_ld = 0;
        end
        if (m_state == 0) begin
            if (!cur_br && !st && hlt) begin m_state = 1; m_cnt = 3; end
        end else if (cur_br) begin
            m_state = 0; m_cnt = 0;
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_state = 2;
        end
    endtask

    // Drive one cycle's inputs (called just after a rising edge); returns at the falling edge.
    task automatic cycle(input logic [31:0] ir, input bit br, input bit e);
        id_ir = ir; mem_br_taken = br; en = e;
        cur_ir = ir; cur_br = br; cur_en = e;
        model_eval();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(32'h0, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; mem_br_taken = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] op;
        if ($urandom_range(0, 99) < 2) op = 6'h3f;
        else begin
            case ($urandom_range(0, 13))
                0: op = 6'd0;   1: op = 6'd1;   2: op = 6'd2;   3: op = 6'd3;
                4: op = 6'd4;   5: op = 6'd8;   6: op = 6'd9;   7: op = 6'd10;
                8: op = 6'd11;  9: op = 6'd12; 10: op = 6'd13; 11: op = 6'd14;
                12: op = 6'd16; default: op = 6'd21;
            endcase
        end
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom_range(0, 15))};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; id_ir = I_HLT; mem_br_taken = 1'b1;
        #3;
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_outputs obs=%b exp=%b", obs, RST_VEC); end
        @(posedge clk); #1;
        en = 1'b1; mem_br_taken = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, RST_VEC); end
        @(negedge clk);
        en = 1'b0; rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_raw_hazard();
        int stalls = 0;
        bit done = 0;
        logic [1:0] last_a = 2'd3, last_b = 2'd3;
        cycle(I_ADDI_R1, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL raw_addi obs=%b exp=%b", obs, exp_vec); end
        tick();
        for (int i = 0; i < 6 && !done; i++) begin
            cycle(I_ADD_R2, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL raw_add obs=%b exp=%b", obs, exp_vec); end
            if (pc_we === 1'b0) stalls++;
            if (exp_vec[10]) begin done = 1; last_a = fwd_a_sel; last_b = fwd_b_sel; end
            tick();
        end
        checks++;
        if (!done || stalls != RAW_STALLS) begin
            errors++; $display("FAIL raw_stall_count got=%0d want=%0d", stalls, RAW_STALLS);
        end
        checks++;
        if (last_a !== 2'(RAW_FWD) || last_b !== 2'(RAW_FWD)) begin
            errors++; $display("FAIL raw_fwd got=%0d/%0d want=%0d", last_a, last_b, RAW_FWD);
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        bit done = 0;
        logic [1:0] last_a = 2'd3;
        nops(3);
        cycle(I_LW_R3, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL lu_lw obs=%b exp=%b", obs, exp_vec); end
        tick();
        for (int i = 0; i < 6 && !done; i++) begin
            cycle(I_SUB_R4, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL lu_sub obs=%b exp=%b", obs, exp_vec); end
            if (pc_we === 1'b0) stalls++;
            if (exp_vec[10]) begin done = 1; last_a = fwd_a_sel; end
            tick();
        end
        checks++;
        if (!done || stalls != LU_STALLS || last_a !== 2'(LU_FWD)) begin
            errors++;
            $display("FAIL lu_result stalls=%0d fwd_a=%0d want stalls=%0d fwd_a=%0d",
                     stalls, last_a, LU_STALLS, LU_FWD);
        end
    endtask

    task automatic test_branch_flush();
        int pulses = 0;
        nops(3);
        cycle(I_ADDI_R1, 1'b0, 1'b1); tick();
        cycle(I_ADD_R2, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec || obs[10:5] !== 6'b111111) begin
            errors++; $display("FAIL br_flush obs=%b exp=%b", obs, exp_vec);
        end
        if (flush_ifid && flush_idex && flush_exmem) pulses++;
        tick();
        cycle(32'h0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL br_after obs=%b exp=%b", obs, exp_vec); end
        if (flush_ifid || flush_idex || flush_exmem) pulses++;
        tick();
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL br_pulse_count got=%0d want=1", pulses); end
    endtask

    task automatic test_halt();
        int drain = 0;
        bit seen = 0;
        nops(3);
        cycle(I_HLT, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL halt_entry obs=%b exp=%b", obs, exp_vec); end
        tick();
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(I_HLT, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL halt_drain obs=%b exp=%b", obs, exp_vec); end
            if (halted === 1'b1) seen = 1; else drain++;
            tick();
        end
        checks++;
        if (!seen || drain != 3) begin errors++; $display("FAIL halt_drain_len got=%0d want=3", drain); end
        for (int i = 0; i < 100; i++) begin
            cycle(rand_ir(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (halted !== 1'b1 || obs[10:5] !== 6'b000000) begin
                errors++; $display("FAIL halt_hold cyc=%0d obs=%b want halted, enables 0", i, obs);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_halt_squash();
        bit ever = 0;
        cycle(I_HLT, 1'b0, 1'b1); tick();
        cycle(I_HLT, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL squash_br obs=%b exp=%b", obs, exp_vec); end
        tick();
        for (int i = 0; i < 6; i++) begin
            cycle(32'h0, 1'b0, 1'b1);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL squash_run obs=%b exp=%b", obs, exp_vec); end
            if (halted !== 1'b0) ever = 1;
            tick();
        end
        checks++;
        if (ever) begin errors++; $display("FAIL squash_halted got=1 want=0"); end
    endtask

    task automatic test_async_reset();
        cycle(I_ADDI_R1, 1'b0, 1'b1); tick();
        cycle(I_HLT, 1'b0, 1'b1); tick();
        cycle(I_HLT, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec) begin errors++; $display("FAIL ar_drain obs=%b exp=%b", obs, exp_vec); end
        tick();
        #2 en = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL ar_immediate obs=%b exp=%b", obs, RST_VEC); end
        model_reset();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(I_ADD_R2, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_vec || pc_we !== 1'b1) begin
            errors++; $display("FAIL ar_no_false_stall obs=%b exp=%b", obs, exp_vec);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ir;
        int halt_wait = 0;
        ir = rand_ir();
        for (int i = 0; i < 600; i++) begin
            cycle(ir, 1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 85));
            checks++;
            if (obs !== exp_vec) begin
                errors++; $display("FAIL rand cyc=%0d ir=%h obs=%b exp=%b", i, ir, obs, exp_vec);
            end
            if (exp_vec[7]) ir = 32'h0;
            else if (exp_vec[9]) ir = rand_ir();
            tick();
            if (m_state == 2) halt_wait++;
            if (halt_wait > 3) begin
                do_reset();
                halt_wait = 0;
                ir = rand_ir();
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_raw_hazard();
        test_load_use();
        test_branch_flush();
        test_halt();
        test_halt_squash();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mips32_pipe_ctrl.md
MIPS32_PIPE_CTRL -- requirements
Module: mips32_pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single pipeline clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port en, input, 1: global advance enable; 0 freezes every pipeline register and all internal state.
REQ-004 SHALL have port id_ir, input, 32: instruction currently held in IF/ID.
REQ-005 SHALL have port mem_br_taken, input, 1: branch or jump in EX/MEM resolved taken (EX_MEM_Cond qualified by opcode).
REQ-006 SHALL have port pc_we, output, 1: PC load enable.
REQ-007 SHALL have port ifid_we, output, 1: IF/ID load enable.
REQ-008 SHALL have port pipe_we, output, 1: ID/EX, EX/MEM and MEM/WB load enable.
REQ-009 SHALL have ports flush_ifid, flush_idex and flush_exmem, output, 1 each: load NOP (32'h0000_0000 with write suppressed) into that register on the next edge.
REQ-010 SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 each: EX operand source (0 regfile, 1 EX/MEM AluOut, 2 MEM/WB result).
REQ-011 SHALL have port halted, output, 1: processor stopped after HLT.

Function
REQ-012 SHALL decode opcode id_ir[31:26]: ADD/SUB/AND/MUL/SLT 000000-000100 (src rs,rt; dst rd=[15:11]); LW 001000, ADDI 001010, SUBI 001011, SLTI 001100 (src rs; dst rt=[20:16]); SW 001001 (src rs,rt; no dst); BNEQZ 001101, BEQZ 001110 (src rs; no dst); J 010000 and HLT 111111 (no src, no dst); any other opcode is a NOP.
REQ-013 SHALL keep a 3-entry scoreboard (EX, MEM, WB), each holding valid, 5-bit dst and an is_load flag; a dst of register 0 SHALL be stored as invalid.
REQ-014 SHALL shift the scoreboard each cycle with en=1: EX takes the ID decode, MEM takes EX, and WB takes MEM; EX takes invalid when a bubble or flush is inserted.
REQ-015 SHALL raise a RAW stall, without forwarding, when any ID source equals the dst of a valid EX or MEM entry; the WB entry never stalls because the register bank writes before it reads.
REQ-016 SHALL, during a stall, drive pc_we=0, ifid_we=0, pipe_we=1 and flush_idex=1 so that a bubble enters EX.
REQ-017 SHALL, when mem_br_taken=1 with en=1, pulse flush_ifid, flush_idex and flush_exmem for 1 cycle, drive pc_we=1, clear the EX and MEM scoreboard entries, and override any stall.
REQ-018 SHALL implement the states RUN, DRAIN and HALTED in the FSM.
REQ-019 SHALL move from RUN to DRAIN when HLT is in ID and there is no stall or flush; on entry to DRAIN, pc_we=0, ifid_we=0, flush_idex=1 and a 2-bit drain counter is set to 3.
REQ-020 SHALL, in DRAIN, decrement the drain counter on each en=1 cycle and move to HALTED when it reaches 0.
REQ-021 SHALL, when mem_br_taken=1 in DRAIN, squash the HLT, clear the counter and return to RUN.
REQ-022 SHALL, in HALTED, drive halted=1 with all write enables 0; HALTED exits only through reset.
REQ-023 SHALL, when en=0 in any state, drive pc_we, ifid_we and pipe_we to 0 and all flushes to 0 whatever the other inputs are.
REQ-024 SHALL produce all enable and flush outputs combinationally from the state, scoreboard, id_ir and mem_br_taken, adding zero cycles of latency.

Reset
REQ-025 SHALL, while rst_n=0, force state to RUN, scoreboard to all invalid, drain counter to 0 and halted=0, taking effect immediately and independent of clk.
REQ-026 SHALL drive pc_we, ifid_we and pipe_we to 1, the flushes to 0 and fwd_*_sel to 0 during reset; a reset during DRAIN or HALTED SHALL return the block to RUN.

Configuration
REQ-027 SHALL, with MIPS32_FWD_EN defined, select fwd_*_sel from the youngest matching valid non-load EX or MEM entry (EX has priority), and stall for 1 cycle only when an ID source matches an EX entry with is_load=1.
REQ-028 SHALL, with MIPS32_FWD_EN undefined, tie fwd_a_sel and fwd_b_sel to 0 and apply full interlock per REQ-015.

Verification
REQ-029 SHALL be covered by this scenario: ADDI r1,r0,5 then ADD r2,r1,r1 with no forwarding gives 2 stall cycles (pc_we=0); with MIPS32_FWD_EN it gives 0 stalls and fwd_a_sel=fwd_b_sel=1.
REQ-030 SHALL be covered by this scenario: LW r3,0(r0) then SUB r4,r3,r0 with MIPS32_FWD_EN gives exactly 1 stall, then fwd_a_sel=2.
REQ-031 SHALL be covered by this scenario: BEQZ taken with mem_br_taken=1 for 1 cycle gives all three flushes high for exactly 1 cycle and no stall that cycle, even with a RAW match in ID.
REQ-032 SHALL be covered by this scenario: HLT in ID gives DRAIN for 3 cycles and then halted=1, and halted stays 1 for 100 cycles.
REQ-033 SHALL be covered by this scenario: HLT entering DRAIN followed by mem_br_taken=1 on the next cycle gives a return to RUN with halted never asserted.
REQ-034 SHALL be covered by this scenario: rst_n dropped mid-DRAIN, asynchronously between edges, immediately gives halted=0, pc_we=1 and an empty scoreboard, with no false stall on the next instruction.
